// File: rtl/pu_policy_ctrl_if.sv
// pu_policy_ctrl_if: policy-entry type and the config/check bundle of the Protection Unit policy controller.
// Config: cfg_valid/cfg_op/cfg_domain/cfg_region/cfg_policy in, cfg_ready/cfg_err/locked out.
// Check: chk_valid/chk_domain/chk_region/chk_read/chk_write in, res_valid/res_allow/viol_cnt out.
// PU_VIOL_IRQ_EN adds viol_irq (to master) and irq_clr (from master).
package pu_pkg;
  typedef struct packed {
    logic read;
    logic write;
  } policy_entry_t;
endpackage

interface pu_policy_ctrl_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int NUM_REGIONS = 8,
  parameter int VIOL_CNT_W  = 16
);
  localparam int DOM_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam int REG_W = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [1:0]            cfg_op;
  logic [DOM_W-1:0]      cfg_domain;
  logic [REG_W-1:0]      cfg_region;
  pu_pkg::policy_entry_t cfg_policy;
  logic                  cfg_err;
  logic                  locked;
  logic                  chk_valid;
  logic [DOM_W-1:0]      chk_domain;
  logic [REG_W-1:0]      chk_region;
  logic                  chk_read;
  logic                  chk_write;
  logic                  res_valid;
  logic                  res_allow;
  logic [VIOL_CNT_W-1:0] viol_cnt;
`ifdef PU_VIOL_IRQ_EN
  logic                  viol_irq;
  logic                  irq_clr;
  modport master (
    output cfg_valid, cfg_op, cfg_domain, cfg_region, cfg_policy,
    output chk_valid, chk_domain, chk_region, chk_read, chk_write, irq_clr,
    input  cfg_ready, cfg_err, locked, res_valid, res_allow, viol_cnt, viol_irq
  );
  modport slave (
    input  cfg_valid, cfg_op, cfg_domain, cfg_region, cfg_policy,
    input  chk_valid, chk_domain, chk_region, chk_read, chk_write, irq_clr,
    output cfg_ready, cfg_err, locked, res_valid, res_allow, viol_cnt, viol_irq
  );
`else
  modport master (
    output cfg_valid, cfg_op, cfg_domain, cfg_region, cfg_policy,
    output chk_valid, chk_domain, chk_region, chk_read, chk_write,
    input  cfg_ready, cfg_err, locked, res_valid, res_allow, viol_cnt
  );
  modport slave (
    input  cfg_valid, cfg_op, cfg_domain, cfg_region, cfg_policy,
    input  chk_valid, chk_domain, chk_region, chk_read, chk_write,
    output cfg_ready, cfg_err, locked, res_valid, res_allow, viol_cnt
  );
`endif
endinterface

// File: rtl/pu_policy_ctrl.sv
// pu_policy_ctrl: Protection Unit policy table with write/clear/lock config and 1-cycle allow/deny checks.
// Ports: clk, rst (async, active-high), bus (pu_policy_ctrl_if.slave: config and check channels).
// PU_VIOL_IRQ_EN adds a sticky violation interrupt (bus.viol_irq, cleared by bus.irq_clr).
module pu_policy_ctrl #(
  parameter int NUM_DOMAINS = 4,
  parameter int NUM_REGIONS = 8,
  parameter int VIOL_CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  pu_policy_ctrl_if.slave bus
);
  localparam int DOM_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam int REG_W = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
  localparam int N     = NUM_DOMAINS * NUM_REGIONS;
  localparam int IDX_W = N > 1 ? $clog2(N) : 1;
  localparam logic [DOM_W:0]   DOM_LIM  = (DOM_W+1)'(NUM_DOMAINS);
  localparam logic [REG_W:0]   REG_LIM  = (REG_W+1)'(NUM_REGIONS);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(N - 1);
  localparam logic [1:0]       OP_WRITE = 2'd0;
  localparam logic [1:0]       OP_CLEAR = 2'd1;
  localparam logic [1:0]       OP_LOCK  = 2'd2;
  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_CLEAR  = 1'b1;
  pu_pkg::policy_entry_t tbl_q [N];
  pu_pkg::policy_entry_t chk_e;
  logic [0:0]            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d, cfg_idx, chk_idx;
  logic                  locked_q, locked_d, cfg_err_q, cfg_err_d;
  logic                  res_valid_q, res_allow_q, res_allow_d;
  logic [VIOL_CNT_W-1:0] viol_q, viol_d;
  logic                  acc, wr_en, cfg_ok, chk_ok, is_wr, is_clr;
  always_comb begin
    cfg_idx     = IDX_W'(32'(bus.cfg_domain) * NUM_REGIONS + 32'(bus.cfg_region));
    chk_idx     = IDX_W'(32'(bus.chk_domain) * NUM_REGIONS + 32'(bus.chk_region));
    chk_e       = tbl_q[chk_idx];
    cfg_ok      = {1'b0, bus.cfg_domain} < DOM_LIM && {1'b0, bus.cfg_region} < REG_LIM;
    chk_ok      = {1'b0, bus.chk_domain} < DOM_LIM && {1'b0, bus.chk_region} < REG_LIM &&
                  state_q == S_IDLE && (bus.chk_read || bus.chk_write);
    acc         = bus.cfg_valid && state_q == S_IDLE;
    is_wr       = acc && bus.cfg_op == OP_WRITE;
    is_clr      = acc && bus.cfg_op == OP_CLEAR;
    wr_en       = is_wr && !locked_q && cfg_ok;
    cfg_err_d   = (is_wr && (locked_q || !cfg_ok)) || (is_clr && locked_q);
    locked_d    = locked_q || (acc && bus.cfg_op == OP_LOCK);
    state_d     = state_q == S_IDLE ? ((is_clr && !locked_q) ? S_CLEAR : S_IDLE)
                                    : (ptr_q == LAST ? S_IDLE : S_CLEAR);
    ptr_d       = state_q == S_CLEAR ? ptr_q + 1'b1 : '0;
    res_allow_d = bus.chk_valid && chk_ok && (!bus.chk_read || chk_e.read) &&
                  (!bus.chk_write || chk_e.write);
    viol_d      = (bus.chk_valid && !res_allow_d && viol_q != '1) ? viol_q + 1'b1 : viol_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_allow_q <= 1'b0;
      viol_q      <= '0;
    end else begin
      if (state_q == S_CLEAR) tbl_q[ptr_q] <= '0;
      else if (wr_en) tbl_q[cfg_idx] <= bus.cfg_policy;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      locked_q    <= locked_d;
      cfg_err_q   <= cfg_err_d;
      res_valid_q <= bus.chk_valid;
      res_allow_q <= res_allow_d;
      viol_q      <= viol_d;
    end
  end
  assign bus.cfg_ready = state_q == S_IDLE;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.locked    = locked_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_allow = res_allow_q;
  assign bus.viol_cnt  = viol_q;
`ifdef PU_VIOL_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else irq_q <= (res_valid_q && !res_allow_q) ? 1'b1 : (bus.irq_clr ? 1'b0 : irq_q);
  end
  assign bus.viol_irq = irq_q;
`endif
endmodule

// File: tb/tb_pu_policy_ctrl.sv
// tb_pu_policy_ctrl: directed bench for pu_policy_ctrl (4x8 main instance, 3x6 instance for range/odd-size cases).
module tb_pu_policy_ctrl;
  localparam int ND   = 4;
  localparam int NR   = 8;
  localparam int VW   = 4;
  localparam int VMAX = (1 << VW) - 1;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  int exp_viol = 0;
  int n;
  always #5 clk = ~clk;
  pu_policy_ctrl_if #(.NUM_DOMAINS(ND), .NUM_REGIONS(NR), .VIOL_CNT_W(VW)) bus ();
  pu_policy_ctrl #(.NUM_DOMAINS(ND), .NUM_REGIONS(NR), .VIOL_CNT_W(VW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  pu_policy_ctrl_if #(.NUM_DOMAINS(3), .NUM_REGIONS(6), .VIOL_CNT_W(VW)) bus3 ();
  pu_policy_ctrl #(.NUM_DOMAINS(3), .NUM_REGIONS(6), .VIOL_CNT_W(VW)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all();
    bus.cfg_valid = 1'b0; bus.cfg_op = 2'd3; bus.cfg_domain = '0; bus.cfg_region = '0; bus.cfg_policy = '0;
    bus.chk_valid = 1'b0; bus.chk_domain = '0; bus.chk_region = '0; bus.chk_read = 1'b0; bus.chk_write = 1'b0;
    bus3.cfg_valid = 1'b0; bus3.cfg_op = 2'd3; bus3.cfg_domain = '0; bus3.cfg_region = '0; bus3.cfg_policy = '0;
    bus3.chk_valid = 1'b0; bus3.chk_domain = '0; bus3.chk_region = '0; bus3.chk_read = 1'b0; bus3.chk_write = 1'b0;
`ifdef PU_VIOL_IRQ_EN
    bus.irq_clr = 1'b0;
    bus3.irq_clr = 1'b0;
`endif
  endtask
  task automatic cfg_cmd(logic [1:0] op, int d, int r, logic [1:0] p, logic exp_err);
    check("cfg_ready_before", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1; bus.cfg_op = op; bus.cfg_domain = 2'(d); bus.cfg_region = 3'(r); bus.cfg_policy = p;
    cyc();
    bus.cfg_valid = 1'b0;
    check("cfg_err", bus.cfg_err, exp_err);
    cyc();
    check("cfg_err_pulse_end", bus.cfg_err, 0);
  endtask
  task automatic do_chk(int d, int r, logic rd, logic wr, logic exp_allow);
    bus.chk_valid = 1'b1; bus.chk_domain = 2'(d); bus.chk_region = 3'(r); bus.chk_read = rd; bus.chk_write = wr;
    cyc();
    bus.chk_valid = 1'b0;
    check("res_valid", bus.res_valid, 1);
    check("res_allow", bus.res_allow, exp_allow);
    if (!exp_allow && exp_viol < VMAX) exp_viol++;
    cyc();
    check("res_valid_idle", bus.res_valid, 0);
    check("res_allow_idle", bus.res_allow, 0);
    check("viol_cnt", bus.viol_cnt, exp_viol);
  endtask
  task automatic c3(logic [1:0] op, int d, int r, logic exp_err);
    bus3.cfg_valid = 1'b1; bus3.cfg_op = op; bus3.cfg_domain = 2'(d); bus3.cfg_region = 3'(r); bus3.cfg_policy = 2'b11;
    cyc();
    bus3.cfg_valid = 1'b0;
    check("r3_cfg_err", bus3.cfg_err, exp_err);
  endtask
  task automatic k3(int d, int r, logic exp_allow);
    bus3.chk_valid = 1'b1; bus3.chk_domain = 2'(d); bus3.chk_region = 3'(r); bus3.chk_read = 1'b1; bus3.chk_write = 1'b1;
    cyc();
    bus3.chk_valid = 1'b0;
    check("r3_res_valid", bus3.res_valid, 1);
    check("r3_res_allow", bus3.res_allow, exp_allow);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_cfg_err", bus.cfg_err, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_allow", bus.res_allow, 0);
    check("rst_viol_cnt", bus.viol_cnt, 0);
    do_chk(0, 0, 1, 0, 0);
    cfg_cmd(2'd0, 1, 3, 2'b10, 0);
    do_chk(1, 3, 1, 0, 1);
    do_chk(1, 3, 0, 1, 0);
    do_chk(1, 3, 1, 1, 0);
    do_chk(1, 3, 0, 0, 0);
    cfg_cmd(2'd3, 0, 0, 2'b00, 0);
    bus.cfg_valid = 1'b1; bus.cfg_op = 2'd0; bus.cfg_domain = 2'd2; bus.cfg_region = 3'd5; bus.cfg_policy = 2'b11;
    bus.chk_valid = 1'b1; bus.chk_domain = 2'd2; bus.chk_region = 3'd5; bus.chk_read = 1'b1; bus.chk_write = 1'b1;
    cyc();
    bus.cfg_valid = 1'b0;
    bus.chk_valid = 1'b0;
    check("rbw_res_valid", bus.res_valid, 1);
    check("rbw_old_deny", bus.res_allow, 0);
    check("rbw_cfg_err", bus.cfg_err, 0);
    if (exp_viol < VMAX) exp_viol++;
    cyc();
    check("rbw_viol_cnt", bus.viol_cnt, exp_viol);
    do_chk(2, 5, 1, 1, 1);
    c3(2'd0, 3, 0, 1);
    c3(2'd0, 0, 6, 1);
    c3(2'd0, 2, 5, 0);
    k3(2, 5, 1);
    k3(3, 0, 0);
    k3(0, 6, 0);
    c3(2'd1, 0, 0, 0);
    n = 0;
    while (bus3.cfg_ready === 1'b0 && n < 100) begin
      n++;
      cyc();
    end
    check("r3_clear_len", n, 18);
    k3(2, 5, 0);
    bus.cfg_valid = 1'b1; bus.cfg_op = 2'd1;
    cyc();
    bus.cfg_valid = 1'b0;
    check("clear_cfg_err", bus.cfg_err, 0);
    n = 0;
    while (bus.cfg_ready === 1'b0 && n < 100) begin
      n++;
      bus.chk_valid = 1'b1; bus.chk_domain = 2'd1; bus.chk_region = 3'd3; bus.chk_read = 1'b1; bus.chk_write = 1'b0;
      cyc();
      check("clear_res_valid", bus.res_valid, 1);
      check("clear_deny", bus.res_allow, 0);
      if (exp_viol < VMAX) exp_viol++;
    end
    bus.chk_valid = 1'b0;
    check("clear_len", n, 32);
    cyc();
    check("viol_sat", bus.viol_cnt, VMAX);
    for (int d = 0; d < ND; d++)
      for (int r = 0; r < NR; r++) do_chk(d, r, 1, 0, 0);
    do_chk(2, 5, 0, 1, 0);
`ifdef PU_VIOL_IRQ_EN
    check("irq_set", bus.viol_irq, 1);
    repeat (3) cyc();
    check("irq_sticky", bus.viol_irq, 1);
    bus.irq_clr = 1'b1;
    cyc();
    bus.irq_clr = 1'b0;
    check("irq_clr", bus.viol_irq, 0);
    bus.irq_clr = 1'b1;
    do_chk(0, 0, 1, 0, 0);
    bus.irq_clr = 1'b0;
    check("irq_set_wins", bus.viol_irq, 1);
`endif
    cfg_cmd(2'd2, 0, 0, 2'b00, 0);
    check("locked", bus.locked, 1);
    cfg_cmd(2'd2, 0, 0, 2'b00, 0);
    cfg_cmd(2'd0, 0, 0, 2'b11, 1);
    do_chk(0, 0, 1, 0, 0);
    cfg_cmd(2'd1, 0, 0, 2'b00, 1);
    check("locked_clear_ready", bus.cfg_ready, 1);
    cfg_cmd(2'd3, 0, 0, 2'b00, 0);
    check("locked_sticky", bus.locked, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_locked", bus.locked, 0);
    check("async_rst_viol", bus.viol_cnt, 0);
    exp_viol = 0;
    rst = 1'b0;
    cyc();
    bus.cfg_valid = 1'b1; bus.cfg_op = 2'd1;
    cyc();
    bus.cfg_valid = 1'b0;
    cyc();
    check("mid_clear_ready", bus.cfg_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("mid_clear_rst_ready", bus.cfg_ready, 1);
    rst = 1'b0;
    cyc();
    cfg_cmd(2'd0, 0, 0, 2'b11, 0);
    do_chk(0, 0, 1, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
